avalon_bus_arbiter: RTL

AVALON_BUS_ARBITER -- requirements
Module: avalon_bus_arbiter

---
 rtl/avalon_bus_arbiter_if.sv | 47 ++++
 rtl/avalon_bus_arbiter.sv | 115 +++++++++++
 2 files changed

// File: rtl/avalon_bus_arbiter_if.sv
// Bundle of the instruction port, data port and Avalon master signals
// seen by the two-port Avalon arbiter.
interface avalon_bus_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic        i_err;
    logic [31:0] i_rdata;

    logic        d_req;
    logic        d_write;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        d_ack;
    logic        d_err;
    logic [31:0] d_rdata;

    logic [31:0] address;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        read;
    logic        write;
    logic [31:0] readdata;
    logic        waitrequest;
    logic        busy;

    modport master (
        input  i_req, i_addr,
        output i_ack, i_err, i_rdata,
        input  d_req, d_write, d_addr, d_wdata, d_be,
        output d_ack, d_err, d_rdata,
        output address, writedata, byteenable, read, write,
        input  readdata, waitrequest,
        output busy
    );

    modport slave (
        output i_req, i_addr,
        input  i_ack, i_err, i_rdata,
        output d_req, d_write, d_addr, d_wdata, d_be,
        input  d_ack, d_err, d_rdata,
        input  address, writedata, byteenable, read, write,
        output readdata, waitrequest,
        input  busy
    );
endinterface

// File: rtl/avalon_bus_arbiter.sv
// Two-port (instruction/data) arbiter onto one Avalon-MM master with
// round-robin or data-priority grant and a waitrequest stall timeout.
module avalon_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          ROUND_ROBIN    = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    avalon_bus_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, DONE} state_t;

    localparam logic [31:0] TO_LAST = TIMEOUT_CYCLES - 32'd1;
    localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);

    state_t      state;
    logic        last_d;
    logic        wr_q;
    logic [31:0] stall_cnt;
    logic        pick_d;
    logic        timed_out;

    // last_d=0 means the instruction port was granted last.
    always_comb pick_d = bus.d_req &&
                         (!bus.i_req || !ROUND_ROBIN || !last_d);

    always_comb timed_out = TO_EN && (stall_cnt == TO_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            last_d         <= 1'b0;
            wr_q           <= 1'b0;
            stall_cnt      <= '0;
            bus.i_ack      <= 1'b0;
            bus.i_err      <= 1'b0;
            bus.i_rdata    <= '0;
            bus.d_ack      <= 1'b0;
            bus.d_err      <= 1'b0;
            bus.d_rdata    <= '0;
            bus.address    <= '0;
            bus.writedata  <= '0;
            bus.byteenable <= '0;
            bus.read       <= 1'b0;
            bus.write      <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            bus.i_ack   <= 1'b0;
            bus.i_err   <= 1'b0;
            bus.i_rdata <= '0;
            bus.d_ack   <= 1'b0;
            bus.d_err   <= 1'b0;
            bus.d_rdata <= '0;
            unique case (state)
                IDLE: begin
                    if (pick_d) begin
                        state          <= GRANT_D;
                        last_d         <= 1'b1;
                        wr_q           <= bus.d_write;
                        stall_cnt      <= '0;
                        bus.address    <= bus.d_addr;
                        bus.writedata  <= bus.d_write ? bus.d_wdata : '0;
                        bus.byteenable <= bus.d_be;
                        bus.read       <= ~bus.d_write;
                        bus.write      <= bus.d_write;
                        bus.busy       <= 1'b1;
                    end else if (bus.i_req) begin
                        state          <= GRANT_I;
                        last_d         <= 1'b0;
                        wr_q           <= 1'b0;
                        stall_cnt      <= '0;
                        bus.address    <= bus.i_addr;
                        bus.writedata  <= '0;
                        bus.byteenable <= 4'b1111;
                        bus.read       <= 1'b1;
                        bus.write      <= 1'b0;
                        bus.busy       <= 1'b1;
                    end
                end
                GRANT_I, GRANT_D: begin
                    if (!bus.waitrequest) begin
                        state     <= DONE;
                        bus.read  <= 1'b0;
                        bus.write <= 1'b0;
                        if (state == GRANT_I) begin
                            bus.i_ack   <= 1'b1;
                            bus.i_rdata <= bus.readdata;
                        end else begin
                            bus.d_ack <= 1'b1;
                            if (!wr_q) bus.d_rdata <= bus.readdata;
                        end
                    end else if (timed_out) begin
                        // Abort: ack with err, rdata stays at its cleared 0.
                        state     <= DONE;
                        bus.read  <= 1'b0;
                        bus.write <= 1'b0;
                        if (state == GRANT_I) begin
                            bus.i_ack <= 1'b1;
                            bus.i_err <= 1'b1;
                        end else begin
                            bus.d_ack <= 1'b1;
                            bus.d_err <= 1'b1;
                        end
                    end else begin
                        stall_cnt <= stall_cnt + 32'd1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule
